// File: rtl/exp_max_reduce_if.sv
// Stream interface for exp_max_reduce: exponent beats in, one selection result per frame out.
// The slave modport is the reduction block; the master modport is its driver/consumer.
interface exp_max_reduce_if #(
    parameter int EXP_W = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 12
);
    localparam int IDX_W = CNT_W + $clog2(LANES);

    logic                   mode_min;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*EXP_W-1:0] in_exp;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W-1:0]       out_exp;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_ovf;

    modport master (
        output mode_min, in_valid, in_exp, in_last, out_ready,
        input  in_ready, out_valid, out_exp, out_idx, out_ovf
    );

    modport slave (
        input  mode_min, in_valid, in_exp, in_last, out_ready,
        output in_ready, out_valid, out_exp, out_idx, out_ovf
    );
endinterface

// File: rtl/exp_max_reduce.sv
// Streaming max/min reduction of LANES exponents per beat across a frame, tracking the
// winning element index; one registered result per frame.
//
// state | meaning
// IDLE  | waiting for first beat of a frame
// ACCUM | frame in progress, folding beat winners into the running value
// HOLD  | result presented, waiting for out_ready
module exp_max_reduce #(
    parameter int EXP_W = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 12
) (
    input  logic               CLK,
    input  logic               nRST,
    exp_max_reduce_if.slave    bus
);
    localparam int LW    = $clog2(LANES);
    localparam int IDX_W = CNT_W + LW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic               mode_q;
    logic [EXP_W-1:0]   run_exp;
    logic [IDX_W-1:0]   run_idx;
    logic [CNT_W-1:0]   beat_cnt;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic               accept;
    logic               taken;
    logic               sel_min;

    // True when a should be selected over b; ties favour a (the lower index).
    function automatic logic a_wins(input logic [EXP_W-1:0] a,
                                    input logic [EXP_W-1:0] b,
                                    input logic use_min);
        logic             borrow;
        logic [EXP_W-1:0] unused_diff;
        if (use_min)
            {borrow, unused_diff} = {1'b0, b} - {1'b0, a};
        else
            {borrow, unused_diff} = {1'b0, a} - {1'b0, b};
        return ~borrow;
    endfunction

    assign accept  = bus.in_valid & in_ready_q;
    assign taken   = out_valid_q & bus.out_ready;
    // The first beat compares with the incoming mode; later beats use the latched one.
    assign sel_min = (state == IDLE) ? bus.mode_min : mode_q;

    // Heap-ordered tree: node i combines 2i (lower lanes) and 2i+1, so ties go low.
    logic [EXP_W-1:0] node_exp  [1:2*LANES-1];
    logic [LW-1:0]    node_lane [1:2*LANES-1];

    for (genvar g = 0; g < LANES; g++) begin : g_leaf
        assign node_exp[LANES+g]  = bus.in_exp[g*EXP_W +: EXP_W];
        assign node_lane[LANES+g] = LW'(g);
    end

    for (genvar g = 1; g < LANES; g++) begin : g_node
        logic left_wins;
        assign left_wins    = a_wins(node_exp[2*g], node_exp[2*g+1], sel_min);
        assign node_exp[g]  = left_wins ? node_exp[2*g]  : node_exp[2*g+1];
        assign node_lane[g] = left_wins ? node_lane[2*g] : node_lane[2*g+1];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            in_ready_q  <= (state_d != HOLD);
            out_valid_q <= (state_d == HOLD);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = bus.in_last ? HOLD : ACCUM;
            ACCUM:   if (accept && bus.in_last) state_d = HOLD;
            HOLD:    if (taken) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mode_q   <= 1'b0;
            run_exp  <= '0;
            run_idx  <= '0;
            beat_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (accept && state == IDLE) begin
            mode_q   <= bus.mode_min;
            run_exp  <= node_exp[1];
            run_idx  <= {{CNT_W{1'b0}}, node_lane[1]};
            beat_cnt <= CNT_W'(1);
            ovf_q    <= 1'b0;
        end else if (accept && state == ACCUM) begin
            if (!a_wins(run_exp, node_exp[1], mode_q)) begin
                run_exp <= node_exp[1];
                run_idx <= {beat_cnt, node_lane[1]};
            end
            if (beat_cnt == CNT_MAX)
                ovf_q <= 1'b1;
            else
                beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_exp   = run_exp;
    assign bus.out_idx   = run_idx;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_exp_max_reduce.sv
// Directed bench for exp_max_reduce: a 12-bit-counter instance for the functional scenarios
// and a 2-bit-counter instance for frame overflow.
module tb_exp_max_reduce;
    logic CLK = 1'b0;
    logic nRST;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    exp_max_reduce_if #(.EXP_W(8), .LANES(4), .CNT_W(12)) if_a ();
    exp_max_reduce_if #(.EXP_W(8), .LANES(4), .CNT_W(2))  if_b ();

    exp_max_reduce #(.EXP_W(8), .LANES(4), .CNT_W(12)) dut_a (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (if_a.slave)
    );

    exp_max_reduce #(.EXP_W(8), .LANES(4), .CNT_W(2)) dut_b (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (if_b.slave)
    );

    // Beats are written {lane3, lane2, lane1, lane0}.
    task automatic send_a(input logic [31:0] e, input logic last, input logic m);
        int n = 0;
        if_a.in_valid = 1'b1;
        if_a.in_exp   = e;
        if_a.in_last  = last;
        if_a.mode_min = m;
        while (!if_a.in_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 50) begin
            n_err++;
            $display("FAIL send_a_timeout: in_ready stayed 0, required 1");
        end
        @(posedge CLK); #1;
        if_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] e, input logic last);
        int n = 0;
        if_b.in_valid = 1'b1;
        if_b.in_exp   = e;
        if_b.in_last  = last;
        if_b.mode_min = 1'b0;
        while (!if_b.in_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 50) begin
            n_err++;
            $display("FAIL send_b_timeout: in_ready stayed 0, required 1");
        end
        @(posedge CLK); #1;
        if_b.in_valid = 1'b0;
    endtask

    task automatic take_a();
        if_a.out_ready = 1'b1;
        @(posedge CLK); #1;
        if_a.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (if_a.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", if_a.out_valid); end
        n_cmp++; if (if_a.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", if_a.in_ready); end
        n_cmp++; if (if_a.out_exp !== 8'h00) begin n_err++; $display("FAIL rst_out_exp: got %h want 00", if_a.out_exp); end
        n_cmp++; if (if_a.out_idx !== 14'd0) begin n_err++; $display("FAIL rst_out_idx: got %0d want 0", if_a.out_idx); end
        n_cmp++; if (if_a.out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_out_ovf: got %0b want 0", if_a.out_ovf); end
        // Leave a frame in ACCUM carrying FF, then reset under it.
        send_a({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0, 1'b0);
        nRST = 1'b0;
        @(posedge CLK); @(posedge CLK); #3;
        nRST = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if (if_a.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %0b want 0", if_a.out_valid); end
        n_cmp++; if (if_a.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %0b want 1", if_a.in_ready); end
        send_a({8'h01, 8'h02, 8'h03, 8'h04}, 1'b1, 1'b0);
        n_cmp++; if (if_a.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_post_valid: got %0b want 1", if_a.out_valid); end
        n_cmp++; if (if_a.out_exp !== 8'h04) begin n_err++; $display("FAIL rst_post_exp: got %h want 04", if_a.out_exp); end
        n_cmp++; if (if_a.out_idx !== 14'd0) begin n_err++; $display("FAIL rst_post_idx: got %0d want 0", if_a.out_idx); end
        take_a();
    endtask

    task automatic test_max_single();
        send_a({8'h10, 8'h7F, 8'h80, 8'h03}, 1'b1, 1'b0);
        n_cmp++; if (if_a.out_valid !== 1'b1) begin n_err++; $display("FAIL max_latency: out_valid got %0b want 1", if_a.out_valid); end
        n_cmp++; if (if_a.out_exp !== 8'h80) begin n_err++; $display("FAIL max_exp: got %h want 80", if_a.out_exp); end
        n_cmp++; if (if_a.out_idx !== 14'd1) begin n_err++; $display("FAIL max_idx: got %0d want 1", if_a.out_idx); end
        n_cmp++; if (if_a.out_ovf !== 1'b0) begin n_err++; $display("FAIL max_ovf: got %0b want 0", if_a.out_ovf); end
        take_a();
        n_cmp++; if (if_a.out_valid !== 1'b0) begin n_err++; $display("FAIL max_release: out_valid got %0b want 0", if_a.out_valid); end
    endtask

    task automatic test_tie();
        // Lanes 1 and 2 tie at 40 in beat 0; beat 1 lane 3 ties again. Lowest index is lane 1.
        send_a({8'h05, 8'h40, 8'h40, 8'h01}, 1'b0, 1'b0);
        send_a({8'h40, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0);
        n_cmp++; if (if_a.out_exp !== 8'h40) begin n_err++; $display("FAIL tie_exp: got %h want 40", if_a.out_exp); end
        n_cmp++; if (if_a.out_idx !== 14'd1) begin n_err++; $display("FAIL tie_idx: got %0d want 1", if_a.out_idx); end
        n_cmp++; if (if_a.out_ovf !== 1'b0) begin n_err++; $display("FAIL tie_ovf: got %0b want 0", if_a.out_ovf); end
        take_a();
    endtask

    task automatic test_min_mode();
        // Min over both beats is 00 at beat1 lane3 (idx 7); max mode would give FF at idx 3.
        send_a({8'hFF, 8'hFE, 8'h20, 8'h21}, 1'b0, 1'b1);
        send_a({8'h00, 8'hFF, 8'hFF, 8'hFF}, 1'b1, 1'b0);
        n_cmp++; if (if_a.out_exp !== 8'h00) begin n_err++; $display("FAIL min_exp: got %h want 00", if_a.out_exp); end
        n_cmp++; if (if_a.out_idx !== 14'd7) begin n_err++; $display("FAIL min_idx: got %0d want 7", if_a.out_idx); end
        take_a();
        // A single min beat on its own: smallest is 20 at lane 1.
        send_a({8'hFF, 8'hFE, 8'h20, 8'h21}, 1'b1, 1'b1);
        n_cmp++; if (if_a.out_exp !== 8'h20) begin n_err++; $display("FAIL min1_exp: got %h want 20", if_a.out_exp); end
        n_cmp++; if (if_a.out_idx !== 14'd1) begin n_err++; $display("FAIL min1_idx: got %0d want 1", if_a.out_idx); end
        take_a();
    endtask

    task automatic test_backpressure();
        send_a({8'h01, 8'h02, 8'h03, 8'h04}, 1'b1, 1'b0);
        if_a.in_valid = 1'b1;
        if_a.in_exp   = {8'h33, 8'h11, 8'h22, 8'h00};
        if_a.in_last  = 1'b1;
        if_a.mode_min = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (if_a.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, if_a.in_ready); end
            n_cmp++; if (if_a.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, if_a.out_valid); end
            n_cmp++; if (if_a.out_exp !== 8'h04 || if_a.out_idx !== 14'd0) begin
                n_err++; $display("FAIL bp_hold[%0d]: got exp %h idx %0d want exp 04 idx 0", i, if_a.out_exp, if_a.out_idx);
            end
            @(posedge CLK); #1;
        end
        take_a();
        n_cmp++; if (if_a.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_released: out_valid got %0b want 0", if_a.out_valid); end
        n_cmp++; if (if_a.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %0b want 1", if_a.in_ready); end
        @(posedge CLK); #1;
        if_a.in_valid = 1'b0;
        n_cmp++; if (if_a.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_held_accept: out_valid got %0b want 1", if_a.out_valid); end
        n_cmp++; if (if_a.out_exp !== 8'h33) begin n_err++; $display("FAIL bp_held_exp: got %h want 33", if_a.out_exp); end
        n_cmp++; if (if_a.out_idx !== 14'd3) begin n_err++; $display("FAIL bp_held_idx: got %0d want 3", if_a.out_idx); end
        take_a();
    endtask

    task automatic test_overflow();
        // 2-bit counter saturates at 3; beat 4's winner (05 at lane 2) indexes as 3*4+2.
        for (int i = 0; i < 4; i++)
            send_b({8'h01, 8'h01, 8'h01, 8'h01}, 1'b0);
        send_b({8'h02, 8'h05, 8'h03, 8'h04}, 1'b1);
        n_cmp++; if (if_b.out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %0b want 1", if_b.out_valid); end
        n_cmp++; if (if_b.out_exp !== 8'h05) begin n_err++; $display("FAIL ovf_exp: got %h want 05", if_b.out_exp); end
        n_cmp++; if (if_b.out_idx !== 4'd14) begin n_err++; $display("FAIL ovf_idx: got %0d want 14", if_b.out_idx); end
        n_cmp++; if (if_b.out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b want 1", if_b.out_ovf); end
        if_b.out_ready = 1'b1;
        @(posedge CLK); #1;
        if_b.out_ready = 1'b0;
        // A short frame afterwards must clear the flag.
        send_b({8'h00, 8'h00, 8'h09, 8'h00}, 1'b1);
        n_cmp++; if (if_b.out_ovf !== 1'b0 || if_b.out_idx !== 4'd1) begin
            n_err++; $display("FAIL ovf_clear: got ovf %0b idx %0d want ovf 0 idx 1", if_b.out_ovf, if_b.out_idx);
        end
    endtask

    initial begin
        nRST = 1'b0;
        if_a.in_valid = 1'b0; if_a.in_exp = '0; if_a.in_last = 1'b0; if_a.mode_min = 1'b0; if_a.out_ready = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_exp = '0; if_b.in_last = 1'b0; if_b.mode_min = 1'b0; if_b.out_ready = 1'b0;
        #22;
        nRST = 1'b1;
        @(posedge CLK); #1;
        test_reset();
        test_max_single();
        test_tie();
        test_min_mode();
        test_backpressure();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
